mem_arbiter: RTL and testbench

// - Single owner of the byte-wide RAM/IO bus. Arbitrates between instruction fetch (word reads) and
//   LSB (1/2/4-byte loads/stores); sequences each access byte-serially, little-endian.
// - Returns assembled, sign/zero-extended load data to the LSB and fetched words to ifetch.

---
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus owner: arbitrates fetch and LSB traffic and
// sequences each access byte-serially, little-endian.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_visit_mem,
  input  logic [6:0]  lsb_op_type,
  input  logic [2:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_welcome,
  output logic        lsb_done,
  output logic        lsb_is_load,
  output logic [31:0] lsb_rdata,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      state_q, state_d;
  logic [2:0]  cyc_q, cyc_d, n_q, n_d, op_q, op_d;
  logic        isif_q, isif_d;
  logic [31:0] base_q, base_d, wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d, mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        ifd_q, ifd_d, lsd_q, lsd_d, ld_q, ld_d;
  logic        wel_q, wel_d;
  logic [31:0] ifdata_q, ifdata_d, rdata_q, rdata_d;

  logic [1:0]  bidx;
  logic [2:0]  k1;
  logic [31:0] raw, rd_addr, wr_addr;

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    unique case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op,
                                         input logic [31:0] v);
    logic [31:0] r;
    r = v;
    case (op[1:0])
      2'd0:    r = {{24{v[7] & ~op[2]}}, v[7:0]};
      2'd1:    r = {{16{v[15] & ~op[2]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // raw = assembly register with the byte arriving this cycle merged in
  always_comb begin
    bidx    = cyc_q[1:0] - 2'd2;
    raw     = asm_q;
    raw[{bidx, 3'b000} +: 8] = mem_din;
    k1      = cyc_q + 3'd1;
    rd_addr = base_q + {29'd0, cyc_q};
    wr_addr = base_q + {29'd0, k1};
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    n_d      = n_q;
    op_d     = op_q;
    isif_d   = isif_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    mem_a_d  = mem_a_q;
    dout_d   = dout_q;
    wr_d     = wr_q;
    ifd_d    = 1'b0;
    lsd_d    = 1'b0;
    ld_d     = ld_q;
    ifdata_d = ifdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!rob_clear_up && lsb_visit_mem) begin
          isif_d  = 1'b0;
          base_d  = lsb_addr;
          op_d    = lsb_op;
          n_d     = nbytes(lsb_op[1:0]);
          mem_a_d = lsb_addr;
          if (lsb_op_type == OP_STORE) begin
            state_d = WRITE;
            cyc_d   = 3'd0;
            wdata_d = lsb_wdata;
            dout_d  = lsb_wdata[7:0];
            wr_d    = !(lsb_addr[17:16] == IO_HI && io_buffer_full);
          end else begin
            state_d = READ;
            cyc_d   = 3'd1;
            asm_d   = 32'd0;
          end
        end else if (!rob_clear_up && if_req) begin
          state_d = READ;
          isif_d  = 1'b1;
          base_d  = if_addr;
          op_d    = 3'd2;
          n_d     = 3'd4;
          cyc_d   = 3'd1;
          asm_d   = 32'd0;
          mem_a_d = if_addr;
        end
      end
      READ: begin
        if (rob_clear_up) begin
          state_d = IDLE;
          mem_a_d = 32'd0;
        end else begin
          if (cyc_q < n_q) mem_a_d = rd_addr;
          if (cyc_q >= 3'd2) asm_d = raw;
          if (cyc_q == n_q + 3'd1) begin
            state_d = IDLE;
            mem_a_d = 32'd0;
            if (isif_q) begin
              ifd_d    = 1'b1;
              ifdata_d = raw;
            end else begin
              lsd_d   = 1'b1;
              ld_d    = 1'b1;
              rdata_d = extend(op_q, raw);
            end
          end else begin
            cyc_d = k1;
          end
        end
      end
      WRITE: begin
        // stores are committed, so a flush never interrupts them
        if (wr_q) begin
          if (k1 == n_q) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            mem_a_d = 32'd0;
            dout_d  = 8'd0;
            lsd_d   = 1'b1;
            ld_d    = 1'b0;
            rdata_d = 32'd0;
          end else begin
            cyc_d   = k1;
            mem_a_d = wr_addr;
            dout_d  = wdata_q[{k1[1:0], 3'b000} +: 8];
            wr_d    = !(wr_addr[17:16] == IO_HI && io_buffer_full);
          end
        end else begin
          wr_d = !(mem_a_q[17:16] == IO_HI && io_buffer_full);
        end
      end
      default: state_d = IDLE;
    endcase
    wel_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cyc_q    <= 3'd0;
      n_q      <= 3'd0;
      op_q     <= 3'd0;
      isif_q   <= 1'b0;
      base_q   <= 32'd0;
      wdata_q  <= 32'd0;
      asm_q    <= 32'd0;
      mem_a_q  <= 32'd0;
      dout_q   <= 8'd0;
      wr_q     <= 1'b0;
      ifd_q    <= 1'b0;
      lsd_q    <= 1'b0;
      ld_q     <= 1'b0;
      wel_q    <= 1'b0;
      ifdata_q <= 32'd0;
      rdata_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      n_q      <= n_d;
      op_q     <= op_d;
      isif_q   <= isif_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      asm_q    <= asm_d;
      mem_a_q  <= mem_a_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      ifd_q    <= ifd_d;
      lsd_q    <= lsd_d;
      ld_q     <= ld_d;
      wel_q    <= wel_d;
      ifdata_q <= ifdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign if_done     = ifd_q;
  assign if_data     = ifdata_q;
  assign lsb_welcome = wel_q;
  assign lsb_done    = lsd_q;
  assign lsb_is_load = ld_q;
  assign lsb_rdata   = rdata_q;
  assign mem_dout    = dout_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = wr_q & rdy_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, rob, if_req, lsb_visit, io_full;
  logic [31:0] if_addr, lsb_addr, lsb_wdata;
  logic [6:0]  op_type;
  logic [2:0]  op;
  logic [7:0]  mem_din;
  logic        if_done, lsb_welcome, lsb_done, lsb_is_load, mem_wr;
  logic [31:0] if_data, lsb_rdata, mem_a;
  logic [7:0]  mem_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:1023];
  logic [31:0] q_if [$];
  logic [32:0] q_lsb [$];
  logic [39:0] wlog [$];

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_clear_up(rob),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_data(if_data), .lsb_visit_mem(lsb_visit),
    .lsb_op_type(op_type), .lsb_op(op), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_welcome(lsb_welcome),
    .lsb_done(lsb_done), .lsb_is_load(lsb_is_load),
    .lsb_rdata(lsb_rdata), .io_buffer_full(io_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr)
  );

  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) begin
      wlog.push_back({mem_a, mem_dout});
      if (mem_a[17:16] != 2'b11) ram[mem_a[9:0]] <= mem_dout;
    end
  end

  always @(negedge clk) begin
    if (if_done && lsb_done) begin
      checks++;
      errors++;
      $display("FAIL done_overlap if_done=1 lsb_done=1 required not both");
    end
  end

  task automatic wait_done(output int lat, output bit gi, output bit gl);
    lat = 0; gi = 0; gl = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (if_done || lsb_done) begin
        lat = i; gi = if_done; gl = lsb_done;
        if (if_done) if_req = 1'b0;
        if (lsb_done) lsb_visit = 1'b0;
        break;
      end
    end
  endtask

  task automatic lsb_go(input logic [6:0] t, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    op_type = t; op = o; lsb_addr = a; lsb_wdata = d;
    lsb_visit = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1; rdy = 1; rob = 0; if_req = 0; lsb_visit = 0; io_full = 0;
    if_addr = 0; lsb_addr = 0; lsb_wdata = 0; op_type = 0; op = 0;
    @(negedge clk);
    checks++;
    if ({if_done, lsb_done, lsb_is_load, mem_wr, lsb_welcome} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000",
               {if_done, lsb_done, lsb_is_load, mem_wr, lsb_welcome});
    end
    checks++;
    if ({mem_a, mem_dout} !== 40'd0) begin
      errors++;
      $display("FAIL reset_bus got %h required 0", {mem_a, mem_dout});
    end
    checks++;
    if ({if_data, lsb_rdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {if_data, lsb_rdata});
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    checks++;
    if (lsb_welcome !== 1'b1) begin
      errors++;
      $display("FAIL welcome_idle got %b required 1", lsb_welcome);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] addrs [2];
    int lat; bit gi, gl;
    addrs[0] = 32'h0; addrs[1] = 32'h104;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    for (int k = 0; k < 4; k++) ram[32'h104 + k] = 8'($urandom);
    for (int t = 0; t < 2; t++) begin
      logic [9:0] b;
      b = addrs[t][9:0];
      q_if.push_back({ram[b+3], ram[b+2], ram[b+1], ram[b]});
      @(negedge clk); if_addr = addrs[t]; if_req = 1;
      wait_done(lat, gi, gl);
      checks++;
      if (!gi || gl || q_if.size() == 0) begin
        errors++;
        $display("FAIL fetch_done got if=%b lsb=%b required if=1 lsb=0", gi, gl);
        if_req = 0;
      end else begin
        logic [31:0] e;
        e = q_if.pop_front();
        checks++;
        if (if_data !== e) begin
          errors++;
          $display("FAIL fetch_data got %h required %h", if_data, e);
        end
        checks++;
        if (lat != 6) begin
          errors++;
          $display("FAIL fetch_latency got %0d required 6", lat);
        end
      end
    end
  endtask

  task automatic test_loads;
    logic [2:0]  ops [6];
    logic [31:0] ads [6];
    logic [31:0] exs [6];
    int          lts [6];
    int lat; bit gi, gl;
    ram[16] = 8'h80; ram[17] = 8'h7F; ram[20] = 8'h01; ram[21] = 8'h80;
    ram[24] = 8'h78; ram[25] = 8'h56; ram[26] = 8'h34; ram[27] = 8'hF2;
    ops = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
    ads = '{32'h10, 32'h10, 32'h14, 32'h14, 32'h18, 32'h11};
    exs = '{32'hFFFFFF80, 32'h80, 32'hFFFF8001, 32'h8001,
            32'hF2345678, 32'h7F};
    lts = '{3, 3, 4, 4, 6, 3};
    for (int t = 0; t < 6; t++) begin
      q_lsb.push_back({1'b1, exs[t]});
      lsb_go(LD, ops[t], ads[t], 32'h0);
      wait_done(lat, gi, gl);
      checks++;
      if (!gl || gi || q_lsb.size() == 0) begin
        errors++;
        $display("FAIL load%0d_done got lsb=%b required 1", t, gl);
        lsb_visit = 0;
      end else begin
        logic [32:0] e;
        e = q_lsb.pop_front();
        checks++;
        if ({lsb_is_load, lsb_rdata} !== e) begin
          errors++;
          $display("FAIL load%0d_data got %b/%h required %b/%h", t,
                   lsb_is_load, lsb_rdata, e[32], e[31:0]);
        end
        checks++;
        if (lat != lts[t]) begin
          errors++;
          $display("FAIL load%0d_latency got %0d required %0d", t, lat, lts[t]);
        end
      end
    end
  endtask

  task automatic test_store;
    int lat; bit gi, gl;
    logic [32:0] e;
    wlog.delete();
    q_lsb.push_back({1'b0, 32'h0});
    lsb_go(ST, 3'd2, 32'h20, 32'hDEADBEEF);
    wait_done(lat, gi, gl);
    e = q_lsb.pop_front();
    checks++;
    if (!gl || lat != 5 || {lsb_is_load, lsb_rdata} !== e) begin
      errors++;
      $display("FAIL sw_done got done=%b lat=%0d ld=%b rd=%h required 1/5/0/0",
               gl, lat, lsb_is_load, lsb_rdata);
      lsb_visit = 0;
    end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL sw_count got %0d required 4", wlog.size());
    end else begin
      logic [31:0] wd;
      wd = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
        logic [39:0] ex;
        ex = {32'h20 + k, wd[8*k +: 8]};
        checks++;
        if (wlog[k] !== ex) begin
          errors++;
          $display("FAIL sw_byte%0d got %h required %h", k, wlog[k], ex);
        end
      end
    end
    q_lsb.push_back({1'b1, 32'hDEADBEEF});
    lsb_go(LD, 3'd2, 32'h20, 32'h0);
    wait_done(lat, gi, gl);
    e = q_lsb.pop_front();
    checks++;
    if (!gl || {lsb_is_load, lsb_rdata} !== e) begin
      errors++;
      $display("FAIL sw_readback got %h required %h", lsb_rdata, e[31:0]);
      lsb_visit = 0;
    end
  endtask

  task automatic test_back_to_back;
    int l1, l2; bit gi1, gl1, gi2, gl2;
    q_lsb.push_back({1'b1, 32'hFFFFFF80});
    q_if.push_back({ram[3], ram[2], ram[1], ram[0]});
    @(negedge clk);
    op_type = LD; op = 3'd0; lsb_addr = 32'h10; lsb_visit = 1;
    if_addr = 32'h0; if_req = 1;
    wait_done(l1, gi1, gl1);
    wait_done(l2, gi2, gl2);
    checks++;
    if (!(gl1 && !gi1 && gi2 && !gl2)) begin
      errors++;
      $display("FAIL arb_order got first lsb=%b second if=%b required 1/1",
               gl1, gi2);
      if_req = 0; lsb_visit = 0;
    end else begin
      logic [32:0] el; logic [31:0] ei;
      el = q_lsb.pop_front();
      ei = q_if.pop_front();
      checks++;
      if (l1 != 3 || l2 != 6) begin
        errors++;
        $display("FAIL arb_latency got %0d/%0d required 3/6", l1, l2);
      end
      checks++;
      if ({lsb_is_load, lsb_rdata} !== el || if_data !== ei) begin
        errors++;
        $display("FAIL arb_data got %h/%h required %h/%h",
                 lsb_rdata, if_data, el[31:0], ei);
      end
    end
  endtask

  task automatic test_io_stall;
    int lat, low;
    logic [32:0] e;
    wlog.delete();
    lat = 0; low = 0;
    q_lsb.push_back({1'b0, 32'h0});
    @(negedge clk);
    op_type = ST; op = 3'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h55;
    lsb_visit = 1; io_full = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) io_full = 0;
      if (lsb_done) begin lat = i; break; end
      if (!mem_wr) low++;
    end
    lsb_visit = 0; io_full = 0;
    e = q_lsb.pop_front();
    checks++;
    if (lat != 5 || {lsb_is_load, lsb_rdata} !== e) begin
      errors++;
      $display("FAIL io_done got lat=%0d required 5", lat);
    end
    checks++;
    if (low != 3) begin
      errors++;
      $display("FAIL io_stall_cycles got %0d required 3", low);
    end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {32'h30000, 8'h55}) begin
      errors++;
      $display("FAIL io_write got n=%0d required one write 30000/55", wlog.size());
    end
  endtask

  task automatic test_flush;
    int seen, lat;
    logic [32:0] e;
    for (int t = 0; t < 2; t++) begin
      seen = 0;
      @(negedge clk);
      if (t == 0) begin
        if_addr = 32'h0; if_req = 1;
      end else begin
        op_type = LD; op = 3'd2; lsb_addr = 32'h18; lsb_visit = 1;
      end
      repeat (3) @(negedge clk);
      rob = 1; if_req = 0; lsb_visit = 0;
      @(negedge clk);
      rob = 0;
      checks++;
      if (lsb_welcome !== 1'b1 || mem_a !== 32'h0) begin
        errors++;
        $display("FAIL flush%0d_idle got wel=%b a=%h required 1/0",
                 t, lsb_welcome, mem_a);
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (if_done || lsb_done) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL flush%0d_nodone got %0d pulses required 0", t, seen);
      end
    end
    wlog.delete();
    lat = 0;
    q_lsb.push_back({1'b0, 32'h0});
    lsb_go(ST, 3'd2, 32'h40, 32'h11223344);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) rob = 1;
      if (i == 3) rob = 0;
      if (lsb_done) begin lat = i; break; end
    end
    lsb_visit = 0; rob = 0;
    e = q_lsb.pop_front();
    checks++;
    if (lat != 5 || {lsb_is_load, lsb_rdata} !== e) begin
      errors++;
      $display("FAIL flush_store_done got lat=%0d required 5", lat);
    end
    checks++;
    if (wlog.size() != 4 || wlog[3] !== {32'h43, 8'h11}
        || wlog[0] !== {32'h40, 8'h44}) begin
      errors++;
      $display("FAIL flush_store_bytes got n=%0d required 4", wlog.size());
    end
  endtask

  task automatic test_rdy;
    int lat;
    bit wr_low;
    logic [32:0] e;
    wlog.delete();
    lat = 0; wr_low = 0;
    q_lsb.push_back({1'b0, 32'h0});
    lsb_go(ST, 3'd0, 32'h50, 32'hA5);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rdy = 0;
        #1 wr_low = !mem_wr;
      end
      if (i == 2) rdy = 1;
      if (lsb_done) begin lat = i; break; end
    end
    lsb_visit = 0; rdy = 1;
    e = q_lsb.pop_front();
    checks++;
    if (!wr_low) begin
      errors++;
      $display("FAIL rdy_gate got mem_wr=1 required 0 while rdy low");
    end
    checks++;
    if (lat != 3 || {lsb_is_load, lsb_rdata} !== e) begin
      errors++;
      $display("FAIL rdy_done got lat=%0d required 3", lat);
    end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {32'h50, 8'hA5}) begin
      errors++;
      $display("FAIL rdy_write got n=%0d required one write 50/A5", wlog.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    test_reset();
    test_fetch();
    test_loads();
    test_store();
    test_back_to_back();
    test_io_stall();
    test_flush();
    test_rdy();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
